// File: rtl/spart_pkg.sv
// Shared SPART definitions: arbiter states, processor-side register map and
// baud divisor bytes.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    // Divisor = 50 MHz / (16 * baud) - 1, split into high/low bytes.
    localparam logic [7:0] DBH_4800  = 8'h02;
    localparam logic [7:0] DBL_4800  = 8'h8A;
    localparam logic [7:0] DBH_9600  = 8'h01;
    localparam logic [7:0] DBL_9600  = 8'h45;
    localparam logic [7:0] DBH_19200 = 8'h00;
    localparam logic [7:0] DBL_19200 = 8'hA2;
    localparam logic [7:0] DBH_38400 = 8'h00;
    localparam logic [7:0] DBL_38400 = 8'h50;

endpackage

// File: rtl/spart_bus_arbiter.sv
// Two-master round-robin arbiter for the SPART processor bus with bounded
// locked bursts. All SPART-side outputs decode from registered state only.
module spart_bus_arbiter
    import spart_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       rw0,
    input  logic [1:0] addr0,
    input  logic [7:0] wdata0,
    input  logic       lock0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       rw1,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata1,
    input  logic       lock1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    arb_state_t    state, state_nxt;
    logic          owner, owner_nxt;
    logic          last_owner, last_owner_nxt;
    logic [CW-1:0] burst_cnt, burst_nxt;
    logic          load, load_sel;
    logic          rw_r;
    logic [1:0]    addr_r;
    logic [7:0]    wdata_r;
    logic          req_own, req_oth, lock_own;

    assign req_own  = owner ? req1 : req0;
    assign req_oth  = owner ? req0 : req1;
    assign lock_own = owner ? lock1 : lock0;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        burst_nxt      = burst_cnt;
        load           = 1'b0;
        load_sel       = owner;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever did not own the bus last.
                    load_sel  = (req0 && req1) ? ~last_owner : req1;
                    owner_nxt = load_sel;
                    load      = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: state_nxt = DONE;
            DONE: begin
                if (lock_own && req_own &&
                    ((burst_cnt < CW'(MAX_BURST - 1)) || !req_oth)) begin
                    load      = 1'b1;
                    state_nxt = BUS;
                    if (burst_cnt != {CW{1'b1}})
                        burst_nxt = burst_cnt + CW'(1);
                end else begin
                    last_owner_nxt = owner;
                    burst_nxt      = '0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            rw_r       <= 1'b1;
            addr_r     <= 2'b00;
            wdata_r    <= 8'h00;
            rdata0     <= 8'h00;
            rdata1     <= 8'h00;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_nxt;
            if (load) begin
                rw_r    <= load_sel ? rw1    : rw0;
                addr_r  <= load_sel ? addr1  : addr0;
                wdata_r <= load_sel ? wdata1 : wdata0;
            end
            if (state == BUS && rw_r) begin
                if (owner) rdata1 <= databus;
                else       rdata0 <= databus;
            end
        end
    end

    assign iocs    = (state == BUS);
    assign iorw    = iocs ? rw_r : 1'b1;
    assign ioaddr  = iocs ? addr_r : 2'b00;
    assign ack0    = iocs && !owner;
    assign ack1    = iocs && owner;
    assign databus = (iocs && !rw_r) ? wdata_r : 8'hzz;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Scoreboard bench: master drivers push expected bus cycles per master, a
// negedge monitor pops and checks every SPART bus cycle and the read capture.
module tb_spart_bus_arbiter;
    import spart_pkg::*;

    typedef struct {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_v [2];
    logic       rw_v  [2];
    logic       lock_v[2];
    logic [1:0] addr_v[2];
    logic [7:0] wdata_v[2];
    wire        ack0, ack1, iocs, iorw;
    wire  [1:0] ioaddr;
    wire  [7:0] rdata0, rdata1;
    wire  [7:0] databus;
    logic [7:0] spart_rd = 8'hA5;

    txn_t q0[$], q1[$];
    int   glog_own[$], glog_cyc[$];
    int   cyc = 0;
    int   n_pass = 0, n_total = 0;
    bit         pend = 0, pend_own;
    logic [7:0] pend_val, pend_other;
    int   lat0, lat1, gsz;

    // SPART register model answers reads only while selected.
    assign databus = (iocs && iorw) ? spart_rd : 8'hzz;

    spart_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_v[0]), .rw0(rw_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]),
        .lock0(lock_v[0]), .ack0(ack0), .rdata0(rdata0),
        .req1(req_v[1]), .rw1(rw_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]),
        .lock1(lock_v[1]), .ack1(ack1), .rdata1(rdata1),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("rdata_capture", pend_own ? rdata1 : rdata0, pend_val);
                chk("rdata_other_kept", pend_own ? rdata0 : rdata1, pend_other);
                pend = 0;
            end
            if (iocs) begin
                txn_t t;
                bit   own;
                own = ack1;
                chk("ack_onehot", {30'd0, ack0, ack1}, own ? 2'b01 : 2'b10);
                glog_own.push_back(int'(own));
                glog_cyc.push_back(cyc);
                chk("grant_pending", 32'((own ? q1.size() : q0.size()) != 0), 1);
                if ((own ? q1.size() : q0.size()) != 0) begin
                    t = own ? q1.pop_front() : q0.pop_front();
                    chk("iorw", iorw, t.rw);
                    chk("ioaddr", ioaddr, t.addr);
                    if (!t.rw) chk("databus_wr", databus, t.wdata);
                    else begin
                        pend       = 1;
                        pend_own   = own;
                        pend_val   = spart_rd;
                        pend_other = own ? rdata0 : rdata1;
                    end
                end
            end else begin
                chk("bus_idle", {29'd0, ack0, ack1, iorw}, 3'b001);
                spart_rd = 8'($urandom);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request, hold it until ack, return at the edge ending ack.
    task automatic do_one(input int m, input logic rw, input logic [1:0] addr,
                          input logic [7:0] wd, input logic lk, output int lat);
        txn_t t;
        int   c0, n;
        t.rw = rw; t.addr = addr; t.wdata = wd;
        rw_v[m] = rw; addr_v[m] = addr; wdata_v[m] = wd; lock_v[m] = lk; req_v[m] = 1'b1;
        if (m == 0) q0.push_back(t); else q1.push_back(t);
        c0 = cyc;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m == 0 ? ack0 : ack1) !== 1'b1 && n < 200);
        chk("ack_seen", {31'd0, (m == 0 ? ack0 : ack1)}, 1);
        lat = cyc - c0;
        step(1);
    endtask

    task automatic run_master(input int m, input int n, input int lock_mode, input int gap_max);
        int   lat, g;
        logic lk;
        for (int i = 0; i < n; i++) begin
            lk = (lock_mode == 2) ? 1'($urandom_range(0, 1)) : (lock_mode == 1);
            do_one(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), lk, lat);
            g = $urandom_range(0, gap_max);
            if (g > 0 || i == n - 1) begin
                req_v[m] = 1'b0;
                lock_v[m] = 1'b0;
                if (g > 0) step(g);
            end
        end
    endtask

    task automatic reset_dut();
        for (int i = 0; i < 2; i++) begin req_v[i] = 1'b0; lock_v[i] = 1'b0; end
        rst_n = 1'b0;
        step(2);
        q0.delete(); q1.delete(); glog_own.delete(); glog_cyc.delete();
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic check_log(input string name, input int nexp, input int own[], input int gap[]);
        chk({name, "_grants"}, glog_own.size() >= nexp, 1);
        for (int k = 0; k < nexp && k < glog_own.size(); k++) begin
            chk({name, "_owner"}, glog_own[k], own[k]);
            if (k > 0) chk({name, "_gap"}, glog_cyc[k] - glog_cyc[k-1], gap[k-1]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_total);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; rw_v[i] = 1'b1; lock_v[i] = 1'b0; addr_v[i] = 2'b00; wdata_v[i] = 8'h00;
        end
        // Both masters request while reset is held; master 0 wins first.
        #2;
        fork
            begin do_one(0, 1'b0, ADDR_DBH, 8'h05, 1'b0, lat0); req_v[0] = 1'b0; end
            begin do_one(1, 1'b1, ADDR_DATA, 8'h00, 1'b0, lat1); req_v[1] = 1'b0; end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_iocs", iocs, 0);
                    chk("rst_iorw", iorw, 1);
                    chk("rst_ioaddr", ioaddr, 0);
                    chk("rst_acks", {ack0, ack1}, 0);
                    chk("rst_rdata", {rdata0, rdata1}, 0);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        step(3);
        check_log("first_grant", 2, '{0, 1}, '{3});

        // Isolated accesses: ack one cycle after the request is sampled.
        do_one(0, 1'b0, ADDR_DBH, 8'h05, 1'b0, lat0); req_v[0] = 1'b0;
        chk("write_latency", lat0, 1);
        step(3);
        do_one(1, 1'b1, ADDR_DATA, 8'h00, 1'b0, lat1); req_v[1] = 1'b0;
        chk("read_latency", lat1, 1);
        step(3);

        reset_dut();
        fork run_master(0, 4, 0, 0); run_master(1, 4, 0, 0); join
        step(3);
        check_log("contention", 8, '{0, 1, 0, 1, 0, 1, 0, 1}, '{3, 3, 3, 3, 3, 3, 3});

        reset_dut();
        fork run_master(0, 6, 1, 0); run_master(1, 3, 0, 0); join
        step(3);
        check_log("burst_contended", 6, '{0, 0, 0, 0, 1, 0}, '{2, 2, 2, 3, 3});

        reset_dut();
        run_master(0, 10, 1, 0);
        step(3);
        check_log("burst_alone", 10, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{2, 2, 2, 2, 2, 2, 2, 2, 2});

        // Async reset in the middle of a write bus cycle.
        reset_dut();
        begin
            txn_t t;
            int   n;
            t.rw = 1'b0; t.addr = ADDR_DATA; t.wdata = 8'h8B;
            q0.push_back(t);
            rw_v[0] = 1'b0; addr_v[0] = ADDR_DATA; wdata_v[0] = 8'h8B; req_v[0] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (iocs !== 1'b1 && n < 20);
            chk("abort_reached_bus", iocs, 1);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_iocs", iocs, 0);
            chk("abort_ack", {ack0, ack1}, 0);
            chk("abort_iorw", iorw, 1);
            req_v[0] = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            gsz = glog_own.size();
            step(4);
            chk("abort_no_regrant", glog_own.size(), gsz);
            chk("abort_rdata", {rdata0, rdata1}, 0);
        end

        reset_dut();
        fork run_master(0, 40, 2, 3); run_master(1, 40, 2, 3); join
        step(4);
        chk("random_q0_drained", q0.size(), 0);
        chk("random_q1_drained", q1.size(), 0);
        chk("random_grants", glog_own.size(), 80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
